// File: rtl/ddr_cmd_issuer.sv
// ddr_cmd_issuer: host request to timed single-bank DDR command strobes.
// Define AUTO_PRECHARGE_EN for a closed-page policy (RDA/WRA on every access).
module ddr_cmd_issuer #(
  parameter int WIDTH   = 8,
  parameter int ROWS    = 128,
  parameter int COLUMNS = 64,
  parameter int TRCD    = 2,
  parameter int TRP     = 2,
  parameter int TRAS    = 5,
  parameter int TWR     = 2,
  parameter int TCL     = 2,
  parameter int TREFI   = 200,
  parameter int TRFC    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [$clog2(ROWS)-1:0]    req_row,
  input  logic [$clog2(COLUMNS)-1:0] req_col,
  input  logic [WIDTH-1:0]           req_wdata,
  output logic                       rsp_valid,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       ACT,
  output logic                       PR,
  output logic                       RD,
  output logic                       RDA,
  output logic                       WR,
  output logic                       WRA,
  output logic                       REF,
  output logic [$clog2(ROWS)-1:0]    row,
  output logic [$clog2(COLUMNS)-1:0] column,
  output logic [WIDTH-1:0]           dq_out,
  input  logic [WIDTH-1:0]           dq_in,
  output logic                       wr_req,
  output logic                       rd_req,
  output logic                       busy
);

  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLUMNS);
  localparam int CW  = 16;
  localparam int RFW = $clog2(TREFI);

`ifdef AUTO_PRECHARGE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ACT_WAIT,
    OPEN,
    PRE_WAIT,
    REF_WAIT
  } st_t;

  st_t              st_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    ras_q;
  logic [CW-1:0]    twr_q;
  logic [RFW-1:0]   refc_q;
  logic             ref_pend_q;
  logic             pend_q;
  logic             ap_q;
  logic             p_we_q;
  logic [RW-1:0]    p_row_q;
  logic [CLW-1:0]   p_col_q;
  logic [WIDTH-1:0] p_wd_q;
  logic [RW-1:0]    open_row_q;
  logic [TCL-1:0]   rdp_q;

  logic act_q, pr_q, rd_q, rda_q;
  logic wr_q, wra_q, ref_q;
  logic wrreq_q, rdreq_q, rspv_q;
  logic [RW-1:0]    row_q;
  logic [CLW-1:0]   col_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] rspd_q;

  logic             rdy;
  logic             acc;
  logic             has;
  logic             c_we;
  logic [RW-1:0]    c_row;
  logic [CLW-1:0]   c_col;
  logic [WIDTH-1:0] c_wd;
  logic             idle_go;
  logic             open_go;
  logic             ap_go;
  logic             pr_ok;
  logic             hit;

  always_comb begin
    rdy = (st_q == IDLE || st_q == OPEN) &&
          !pend_q && !ref_pend_q && !ap_q;
    req_ready = rdy & ~halt & ~rst;
    acc   = req_valid & req_ready;
    has   = pend_q | acc;
    c_we  = pend_q ? p_we_q  : req_we;
    c_row = pend_q ? p_row_q : req_row;
    c_col = pend_q ? p_col_q : req_col;
    c_wd  = pend_q ? p_wd_q  : req_wdata;
    idle_go = (st_q == IDLE) ||
              (st_q == PRE_WAIT && cnt_q == '0);
    open_go = (st_q == OPEN && !ap_q) ||
              (st_q == ACT_WAIT && cnt_q == '0);
    ap_go = (st_q == OPEN) && ap_q;
    pr_ok = (ras_q == '0) && (twr_q == '0);
    hit   = (c_row == open_row_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      ras_q      <= '0;
      twr_q      <= '0;
      refc_q     <= '0;
      ref_pend_q <= 1'b0;
      pend_q     <= 1'b0;
      ap_q       <= 1'b0;
      p_we_q     <= 1'b0;
      p_row_q    <= '0;
      p_col_q    <= '0;
      p_wd_q     <= '0;
      open_row_q <= '0;
      rdp_q      <= '0;
      act_q      <= 1'b0;
      pr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rda_q      <= 1'b0;
      wr_q       <= 1'b0;
      wra_q      <= 1'b0;
      ref_q      <= 1'b0;
      wrreq_q    <= 1'b0;
      rdreq_q    <= 1'b0;
      rspv_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      dq_q       <= '0;
      rspd_q     <= '0;
    end else if (!halt) begin
      act_q   <= 1'b0;
      pr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rda_q   <= 1'b0;
      wr_q    <= 1'b0;
      wra_q   <= 1'b0;
      ref_q   <= 1'b0;
      wrreq_q <= 1'b0;
      rdreq_q <= 1'b0;

      if (refc_q == RFW'(TREFI - 1)) begin
        refc_q     <= '0;
        ref_pend_q <= 1'b1;
      end else begin
        refc_q <= refc_q + 1'b1;
      end

      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (ras_q != '0) ras_q <= ras_q - 1'b1;
      if (twr_q != '0) twr_q <= twr_q - 1'b1;

      rdp_q  <= rdp_q << 1;
      rspv_q <= rdp_q[TCL-1];
      if (rdp_q[TCL-1]) rspd_q <= dq_in;

      if (acc) begin
        pend_q  <= 1'b1;
        p_we_q  <= req_we;
        p_row_q <= req_row;
        p_col_q <= req_col;
        p_wd_q  <= req_wdata;
      end

      // Countdown expiry falls straight into the next state's decision.
      if (idle_go) begin
        if (has) begin
          act_q      <= 1'b1;
          row_q      <= c_row;
          open_row_q <= c_row;
          st_q       <= ACT_WAIT;
          cnt_q      <= CW'(TRCD - 1);
          ras_q      <= CW'(TRAS - 1);
        end else if (ref_pend_q) begin
          ref_q <= 1'b1;
          st_q  <= REF_WAIT;
          cnt_q <= CW'(TRFC - 1);
        end else begin
          st_q <= IDLE;
        end
      end else if (open_go) begin
        st_q <= OPEN;
        if (has && hit) begin
          pend_q <= 1'b0;
          col_q  <= c_col;
          ap_q   <= AP;
          if (c_we) begin
            wr_q    <= ~AP;
            wra_q   <= AP;
            wrreq_q <= 1'b1;
            dq_q    <= c_wd;
            twr_q   <= CW'(TWR - 1);
          end else begin
            rd_q     <= ~AP;
            rda_q    <= AP;
            rdreq_q  <= 1'b1;
            rdp_q[0] <= 1'b1;
          end
        end else if ((has || ref_pend_q) && pr_ok) begin
          pr_q  <= 1'b1;
          st_q  <= PRE_WAIT;
          cnt_q <= CW'(TRP - 1);
        end
      end else if (ap_go) begin
        if (pr_ok) begin
          ap_q  <= 1'b0;
          st_q  <= PRE_WAIT;
          cnt_q <= CW'(TRP - 1);
        end
      end else if (st_q == REF_WAIT && cnt_q == '0) begin
        st_q       <= IDLE;
        ref_pend_q <= 1'b0;
      end
    end
  end

  assign ACT       = act_q & ~halt;
  assign PR        = pr_q & ~halt;
  assign RD        = rd_q & ~halt;
  assign RDA       = rda_q & ~halt;
  assign WR        = wr_q & ~halt;
  assign WRA       = wra_q & ~halt;
  assign REF       = ref_q & ~halt;
  assign wr_req    = wrreq_q & ~halt;
  assign rd_req    = rdreq_q & ~halt;
  assign rsp_valid = rspv_q & ~halt;
  assign rsp_rdata = rspd_q;
  assign row       = row_q;
  assign column    = col_q;
  assign dq_out    = dq_q;
  assign busy      = !(st_q == IDLE || st_q == OPEN) || pend_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Directed bench for ddr_cmd_issuer (open-page build).
module tb_ddr_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [6:0] req_row;
  logic [5:0] req_col;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       ACT, PR, RD, RDA, WR, WRA, REF;
  logic [6:0] row;
  logic [5:0] column;
  logic [7:0] dq_out;
  logic [7:0] dq_in;
  logic       wr_req;
  logic       rd_req;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int waited;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ACT  = 7'b1000000;
  localparam logic [6:0] C_PR   = 7'b0100000;
  localparam logic [6:0] C_RD   = 7'b0010000;
  localparam logic [6:0] C_WR   = 7'b0000100;
  localparam logic [6:0] C_REF  = 7'b0000001;

  logic [6:0] cmd;
  assign cmd = {ACT, PR, RD, RDA, WR, WRA, REF};

  always #5 clk = ~clk;

  ddr_cmd_issuer dut (
    .clk(clk), .rst(rst), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_row(req_row),
    .req_col(req_col), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ACT(ACT), .PR(PR), .RD(RD), .RDA(RDA),
    .WR(WR), .WRA(WRA), .REF(REF),
    .row(row), .column(column), .dq_out(dq_out),
    .dq_in(dq_in), .wr_req(wr_req), .rd_req(rd_req),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [6:0] r,
                     input logic [5:0] c, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_row   = r;
    req_col   = c;
    req_wdata = d;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_row = '0; req_col = '0; req_wdata = '0; dq_in = 8'hA5;
    tick(); tick();
    chk("rst_cmd", 32'(cmd), 32'(C_NONE));
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(req_ready), 1);

    // read row 0 col 1 from idle
    req(1'b0, 7'd0, 6'd1, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("t1_act", 32'(cmd), 32'(C_ACT));
    chk("t1_row", 32'(row), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_gap", 32'(cmd), 32'(C_NONE));
    tick();
    chk("t1_rd", 32'(cmd), 32'(C_RD));
    chk("t1_col", 32'(column), 1);
    chk("t1_rdreq", 32'(rd_req), 1);
    tick();
    chk("t1_rsp_early", 32'(rsp_valid), 0);
    tick();
    chk("t1_rsp", 32'(rsp_valid), 1);
    chk("t1_rdata", 32'(rsp_rdata), 32'h A5);
    tick();
    chk("t1_rsp_off", 32'(rsp_valid), 0);
    chk("t1_busy_off", 32'(busy), 0);

    // row hit write
    req(1'b1, 7'd0, 6'd3, 8'h01);
    tick();
    chk("t2_wr", 32'(cmd), 32'(C_WR));
    chk("t2_wrreq", 32'(wr_req), 1);
    chk("t2_dq", 32'(dq_out), 32'h01);
    chk("t2_col", 32'(column), 3);

    // row miss read row 5, PR gated by tWR
    dq_in = 8'h3C;
    req(1'b0, 7'd5, 6'd7, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("t3_twr_hold", 32'(cmd), 32'(C_NONE));
    tick();
    chk("t3_pr", 32'(cmd), 32'(C_PR));
    tick();
    chk("t3_gap", 32'(cmd), 32'(C_NONE));
    tick();
    chk("t3_act", 32'(cmd), 32'(C_ACT));
    chk("t3_row", 32'(row), 5);
    tick();
    tick();
    chk("t3_rd", 32'(cmd), 32'(C_RD));
    chk("t3_col", 32'(column), 7);
    tick();
    tick();
    chk("t3_rsp", 32'(rsp_valid), 1);
    chk("t3_rdata", 32'(rsp_rdata), 32'h3C);

    // halt over the RD cycle
    dq_in = 8'h5A;
    req(1'b0, 7'd5, 6'd2, 8'h00);
    tick();
    req_valid = 1'b0;
    halt = 1'b1;
    #1;
    chk("t5_h0", 32'(cmd), 32'(C_NONE));
    chk("t5_ready", 32'(req_ready), 0);
    tick();
    chk("t5_h1", 32'(cmd), 32'(C_NONE));
    tick();
    chk("t5_h2", 32'(cmd), 32'(C_NONE));
    tick();
    halt = 1'b0;
    #1;
    chk("t5_rd", 32'(cmd), 32'(C_RD));
    chk("t5_col", 32'(column), 2);
    tick();
    chk("t5_gap", 32'(cmd), 32'(C_NONE));
    chk("t5_rsp_early", 32'(rsp_valid), 0);
    tick();
    chk("t5_rsp", 32'(rsp_valid), 1);
    chk("t5_rdata", 32'(rsp_rdata), 32'h5A);

    // async reset between RD and data return
    req(1'b0, 7'd5, 6'd4, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("t6_rd", 32'(cmd), 32'(C_RD));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_cmd0", 32'(cmd), 32'(C_NONE));
    chk("t6_busy0", 32'(busy), 0);
    chk("t6_col0", 32'(column), 0);
    rst = 1'b0;
    tick();
    chk("t6_rsp_a", 32'(rsp_valid), 0);
    tick();
    chk("t6_rsp_b", 32'(rsp_valid), 0);
    req(1'b0, 7'd5, 6'd4, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("t6_act", 32'(cmd), 32'(C_ACT));
    chk("t6_row", 32'(row), 5);
    tick();
    tick();
    chk("t6_rd2", 32'(cmd), 32'(C_RD));
    tick();
    tick();
    chk("t6_rsp", 32'(rsp_valid), 1);

    // refresh with row 5 open
    waited = 0;
    while (cmd !== C_PR && waited < 300) begin
      tick();
      waited++;
    end
    chk("t4_pr_time", 32'(waited), 194);
    chk("t4_ready", 32'(req_ready), 0);
    tick();
    chk("t4_gap", 32'(cmd), 32'(C_NONE));
    tick();
    chk("t4_ref", 32'(cmd), 32'(C_REF));
    chk("t4_busy", 32'(busy), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4_rfc_ready", 32'(req_ready), 0);
    end
    tick();
    chk("t4_ready_back", 32'(req_ready), 1);
    chk("t4_idle", 32'(busy), 0);
    req(1'b0, 7'd5, 6'd0, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("t4_act", 32'(cmd), 32'(C_ACT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
